rr_index_arbiter: RTL and testbench

RR_INDEX_ARBITER -- requirements
Module: rr_index_arbiter

---
 rtl/rr_index_arbiter.sv | 105 ++++++++++
 tb/tb_rr_index_arbiter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/rr_index_arbiter.sv
// Round-robin arbiter over 8 requesters that presents the winner as a binary
// index. A grant is held until the consumer acks it or until a hold timer
// expires. Every output comes straight from a flop.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | no live grant; arbitrate on any non-zero req
// GRANT | gnt_idx is live; wait for gnt_ack or hold-timer expiry
module rr_index_arbiter #(
   parameter int TIMEOUT = 15
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] req,
   input  logic       gnt_ack,
   output logic       gnt_valid,
   output logic [2:0] gnt_idx,
   output logic       gnt_timeout
);

   typedef enum logic {IDLE, GRANT} state_t;

   // Last timer value before a forced release.
   localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

   state_t     state_q, state_d;
   logic [2:0] ptr_q, ptr_d;
   logic [7:0] timer_q, timer_d;
   logic       valid_q, valid_d;
   logic [2:0] idx_q, idx_d;
   logic       tmo_q, tmo_d;
   logic [2:0] winner;
   logic [2:0] cand;

   // Search ptr, ptr+1, ... ptr+7 (mod 8). Walking the offsets from high to
   // low lets the nearest set bit overwrite any farther one.
   always_comb begin
      winner = ptr_q;
      cand   = ptr_q;
      for (int k = 7; k >= 0; k--) begin
         cand = ptr_q + 3'(k);
         if (req[cand]) winner = cand;
      end
   end

   // Next-state and next-output logic. Ack beats timeout when both apply.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      timer_d = timer_q;
      valid_d = 1'b0;
      idx_d   = idx_q;
      tmo_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (req != 8'd0) begin
               state_d = GRANT;
               valid_d = 1'b1;
               idx_d   = winner;
               timer_d = 8'd0;
            end
         end
         GRANT: begin
            if (gnt_ack) begin
               state_d = IDLE;
               ptr_d   = idx_q + 3'd1;
            end else if (timer_q == TIMER_LAST) begin
               state_d = IDLE;
               ptr_d   = idx_q + 3'd1;
               tmo_d   = 1'b1;
            end else begin
               valid_d = 1'b1;
               timer_d = timer_q + 8'd1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers; reset wins over everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q   <= 3'd0;
         timer_q <= 8'd0;
         valid_q <= 1'b0;
         idx_q   <= 3'd0;
         tmo_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         timer_q <= timer_d;
         valid_q <= valid_d;
         idx_q   <= idx_d;
         tmo_q   <= tmo_d;
      end
   end

   assign gnt_valid   = valid_q;
   assign gnt_idx     = idx_q;
   assign gnt_timeout = tmo_q;

endmodule

// File: tb/tb_rr_index_arbiter.sv
// Bench for rr_index_arbiter (TIMEOUT=4). Stimulus pushes the expected grants
// into a queue; a monitor pops one entry each time a grant ends and checks
// the index, how long it was held, and whether it ended by timeout.
module tb_rr_index_arbiter;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] req = 8'd0;
   logic       gnt_ack = 1'b0;
   logic       gnt_valid;
   logic [2:0] gnt_idx;
   logic       gnt_timeout;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [2:0] idx;
      int         len;
      logic       tmo;
   } exp_t;

   exp_t exp_q[$];

   rr_index_arbiter #(.TIMEOUT(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .gnt_ack    (gnt_ack),
      .gnt_valid  (gnt_valid),
      .gnt_idx    (gnt_idx),
      .gnt_timeout(gnt_timeout)
   );

   always #5 clk = ~clk;

   // Monitor: samples on the falling edge, away from the active edge.
   logic       prev_valid = 1'b0;
   logic [2:0] cur_idx = 3'd0;
   int         cur_len = 0;

   always @(negedge clk) begin
      exp_t e;
      if (gnt_valid && !prev_valid) begin
         cur_idx = gnt_idx;
         cur_len = 1;
      end else if (gnt_valid && prev_valid) begin
         cur_len++;
         checks++;
         if (gnt_idx !== cur_idx) begin
            errors++;
            $display("FAIL idx_stable: got %0d want %0d", gnt_idx, cur_idx);
         end
      end else if (!gnt_valid && prev_valid) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_grant: idx %0d len %0d with nothing expected", cur_idx, cur_len);
         end else begin
            e = exp_q.pop_front();
            checks += 2;
            if (cur_idx !== e.idx) begin
               errors++;
               $display("FAIL grant_idx: got %0d want %0d", cur_idx, e.idx);
            end
            if (cur_len != e.len) begin
               errors++;
               $display("FAIL grant_len: got %0d want %0d (idx %0d)", cur_len, e.len, e.idx);
            end
            if (gnt_timeout !== e.tmo) begin
               errors++;
               $display("FAIL grant_tmo: got %0b want %0b (idx %0d)", gnt_timeout, e.tmo, e.idx);
            end
         end
      end
      if (gnt_timeout === 1'b1 && !(!gnt_valid && prev_valid)) begin
         checks++;
         errors++;
         $display("FAIL stray_timeout: gnt_timeout=1 outside a grant release");
      end
      prev_valid = gnt_valid;
   end

   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic expect_grant(input logic [2:0] idx, input int len, input logic tmo);
      exp_t e;
      e.idx = idx;
      e.len = len;
      e.tmo = tmo;
      exp_q.push_back(e);
   endtask

   task automatic check_outputs(input string name, input logic v, input logic [2:0] i,
                                input logic t);
      checks++;
      if (gnt_valid !== v || gnt_idx !== i || gnt_timeout !== t) begin
         errors++;
         $display("FAIL %s: got valid=%0b idx=%0d tmo=%0b want valid=%0b idx=%0d tmo=%0b",
                  name, gnt_valid, gnt_idx, gnt_timeout, v, i, t);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
   endtask

   // Stimulus: one grant, acked in its first valid cycle.
   task automatic quick_grant(input logic [7:0] r, input logic [2:0] idx);
      expect_grant(idx, 1, 1'b0);
      req = r;
      tick();
      req = 8'd0;
      gnt_ack = 1'b1;
      tick();
      gnt_ack = 1'b0;
   endtask

   initial begin
      do_reset();
      check_outputs("reset_state", 1'b0, 3'd0, 1'b0);

      // Full request vector, one ack per grant: 0..7 then wrap to 0.
      req = 8'hFF;
      for (int g = 0; g < 9; g++) begin
         expect_grant(3'(g % 8), 1, 1'b0);
         tick();
         gnt_ack = 1'b1;
         tick();
         gnt_ack = 1'b0;
      end
      req = 8'd0;
      tick();

      // Single requester 2 after reset, then wrap search from ptr=3.
      do_reset();
      quick_grant(8'b0000_0100, 3'd2);
      quick_grant(8'b0000_0101, 3'd0);

      // Timeout on idx 5 (req withdrawn during the grant); ptr moves to 6.
      expect_grant(3'd5, 4, 1'b1);
      req = 8'b0010_0000;
      tick();
      req = 8'd0;
      tick(4);
      tick();
      quick_grant(8'b0110_0001, 3'd6);

      // Ack on the 4th valid cycle beats the timeout.
      expect_grant(3'd5, 4, 1'b0);
      req = 8'b0010_0000;
      tick();
      req = 8'd0;
      tick(3);
      gnt_ack = 1'b1;
      tick();
      gnt_ack = 1'b0;
      tick();

      // Reset in the 2nd cycle of a grant of idx 6, req still asserted.
      expect_grant(3'd6, 2, 1'b0);
      req = 8'h40;
      tick(2);
      rst = 1'b1;
      tick();
      check_outputs("reset_mid_grant", 1'b0, 3'd0, 1'b0);
      rst = 1'b0;
      expect_grant(3'd6, 1, 1'b0);
      tick();
      check_outputs("regrant_after_reset", 1'b1, 3'd6, 1'b0);
      req = 8'd0;
      gnt_ack = 1'b1;
      tick();
      gnt_ack = 1'b0;

      // Ack while idle is ignored; gnt_idx keeps the last granted index.
      gnt_ack = 1'b1;
      tick(2);
      check_outputs("idle_ack_ignored", 1'b0, 3'd6, 1'b0);
      gnt_ack = 1'b0;
      tick(2);

      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL pending_grants: %0d expected grants never seen", exp_q.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1, "watchdog");
   end

endmodule
